fir_filter_tap_sequencer: RTL and testbench
===========================================

FIR_FILTER_TAP_SEQUENCER -- requirements
Module: fir_filter_tap_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the sample width (signed).
REQ-002 SHALL have parameter COEFF_WIDTH, default 16, meaning the coefficient width (signed).
REQ-003 SHALL have parameter TAPS, default 8, meaning the filter length (>=2); define AW = $clog2(TAPS).
REQ-004 SHALL have port clk, input, 1 bit: the single clock.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port sample_in, input, DATA_WIDTH bits: the new input sample.
REQ-007 SHALL have port sample_valid_in, input, 1 bit: sample_in is valid.
REQ-008 SHALL have port sample_ready_out, output, 1 bit: the block can accept a sample.
REQ-009 SHALL have port coeff_wr_en_in, input, 1 bit: coefficient write strobe (only when the macro is set).
REQ-010 SHALL have port coeff_wr_addr_in, input, AW bits: coefficient index (only when the macro is set).
REQ-011 SHALL have port coeff_wr_data_in, input, COEFF_WIDTH bits: coefficient value (only when the macro is set).
REQ-012 SHALL have port mult_sample_out, output, DATA_WIDTH bits: sample operand to the multiplier.
REQ-013 SHALL have port mult_coeff_out, output, COEFF_WIDTH bits: coefficient operand to the multiplier.
REQ-014 SHALL have port tap_valid_out, output, 1 bit: the operand pair is valid.
REQ-015 SHALL have port overwrite_out, output, 1 bit: first tap; the accumulator restarts.
REQ-016 SHALL have port last_out, output, 1 bit: final tap; drives the add stage output_valid_in.

Function
REQ-017 SHALL implement a two-state FSM, IDLE and RUN.
REQ-018 SHALL drive sample_ready_out=1 only in IDLE and not in reset.
REQ-019 SHALL, on accept (sample_valid_in && sample_ready_out), write sample_in into a circular delay line at wr_ptr, set tap index k=0 and go to RUN.
REQ-020 SHALL, in RUN, present each cycle the delay-line entry at (wr_ptr-k) mod TAPS together with coeff[k], with tap_valid_out=1.
REQ-021 SHALL assert overwrite_out only at k=0 and last_out only at k=TAPS-1.
REQ-022 SHALL register all outputs, so the first tap appears the cycle after accept; TAPS tap cycles follow back-to-back.
REQ-023 SHALL, after k=TAPS-1, advance wr_ptr with wrap from TAPS-1 to 0 and return to IDLE, giving throughput of one sample per TAPS+1 cycles.
REQ-024 SHALL drive tap_valid_out, overwrite_out, last_out, mult_sample_out and mult_coeff_out to 0 whenever not in RUN.
REQ-025 SHALL hold the stored value of samples never written at 0 (reset value).
REQ-026 SHALL commit a coefficient write in IDLE; a write in the same cycle as an accept SHALL be visible to that run.
REQ-027 SHALL silently ignore coefficient writes during RUN.
REQ-028 SHALL ignore sample_valid_in while sample_ready_out=0; no sample is stored.

Reset
REQ-029 SHALL, on rst, go to IDLE, set wr_ptr=0 and k=0, clear the delay line to 0, and drive all outputs to 0, including sample_ready_out.
REQ-030 SHALL, on rst asserted mid-RUN, abort the run immediately with no further tap_valid_out and no last_out.
REQ-031 SHALL assert sample_ready_out=1 on the first cycle after rst deasserts.

Configuration
REQ-032 SHALL, with FIR_TAP_SEQ_COEFF_WR_EN defined, include the coeff_wr_* ports and a writable coefficient register bank that resets to 0.
REQ-033 SHALL, without FIR_TAP_SEQ_COEFF_WR_EN, omit the coeff_wr_* ports and load the coefficients at reset from the package constant FIR_DEFAULT_COEFFS.

Structure
REQ-034 SHALL place the FSM state enum typedef, FIR_DEFAULT_COEFFS and the default width constants in package fir_filter_pkg.
REQ-035 SHALL contain one sub-module, fir_filter_delay_line: circular sample buffer with write port and one combinational read port.

Verification
REQ-036 SHALL verify impulse response: TAPS=4, coeffs {1,2,3,4}, sample 5 -> samples 5,0,0,0 with coeffs 1,2,3,4; overwrite on tap 0; last on tap 3.
REQ-037 SHALL verify history order: then sample 7 -> samples 7,5,0,0; sample_ready_out is low for exactly 4 cycles after each accept.
REQ-038 SHALL verify wrap: feed 1..6 with TAPS=4 -> the 6th run presents samples 6,5,4,3.
REQ-039 SHALL verify coefficient write hazards (macro on): write coeff[2]=9 during RUN -> ignored; the same write in IDLE simultaneous with an accept -> this run uses 9.
REQ-040 SHALL verify reset mid-run: rst at tap 1 -> no last_out; outputs 0; ready=1 one cycle after release; the next sample sees history cleared to 0.
REQ-041 SHALL verify backpressure: sample_valid_in held high continuously -> exactly one accept per TAPS+1 cycles and no sample dropped or duplicated.

Source files
------------

// File: rtl/fir_filter_pkg.sv
// Shared types and constants for the FIR tap sequencer: FSM state encoding,
// default widths and the fixed coefficient set used when coefficients are not writable.
package fir_filter_pkg;

    localparam int FIR_DATA_WIDTH  = 16;
    localparam int FIR_COEFF_WIDTH = 16;
    localparam int FIR_TAPS        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Symmetric low-pass-ish kernel; longer filters reuse it cyclically.
    localparam int FIR_DEFAULT_COEFF_CNT = 16;
    localparam int FIR_DEFAULT_COEFFS [FIR_DEFAULT_COEFF_CNT] =
        '{1, 2, 3, 4, 5, 6, 7, 8, 8, 7, 6, 5, 4, 3, 2, 1};

    function automatic int fir_default_coeff(input int idx);
        return FIR_DEFAULT_COEFFS[idx % FIR_DEFAULT_COEFF_CNT];
    endfunction

endpackage

// File: rtl/fir_filter_delay_line.sv
// Circular sample history: one synchronous write port, one combinational read port.
// The whole history clears on reset so unwritten slots read as zero.
module fir_filter_delay_line
    import fir_filter_pkg::*;
#(
    parameter  int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter  int DEPTH      = FIR_TAPS,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_filter_tap_sequencer.sv
// Sequences one sample through TAPS multiply operand pairs (newest sample first).
// Define FIR_TAP_SEQ_COEFF_WR_EN for a writable coefficient bank; otherwise fixed defaults.
module fir_filter_tap_sequencer
    import fir_filter_pkg::*;
#(
    parameter  int DATA_WIDTH  = FIR_DATA_WIDTH,
    parameter  int COEFF_WIDTH = FIR_COEFF_WIDTH,
    parameter  int TAPS        = FIR_TAPS,
    localparam int AW          = $clog2(TAPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  sample_in,
    input  logic                   sample_valid_in,
    output logic                   sample_ready_out,
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
    input  logic                   coeff_wr_en_in,
    input  logic [AW-1:0]          coeff_wr_addr_in,
    input  logic [COEFF_WIDTH-1:0] coeff_wr_data_in,
`endif
    output logic [DATA_WIDTH-1:0]  mult_sample_out,
    output logic [COEFF_WIDTH-1:0] mult_coeff_out,
    output logic                   tap_valid_out,
    output logic                   overwrite_out,
    output logic                   last_out
);

    state_t                 state;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          k;
    logic [AW-1:0]          rd_ptr;
    logic [COEFF_WIDTH-1:0] coeff [TAPS];
    logic [COEFF_WIDTH-1:0] coeff0;
    logic [DATA_WIDTH-1:0]  dl_rd;
    logic                   accept;

    assign accept = sample_valid_in && sample_ready_out;

    function automatic logic [AW-1:0] ptr_dec(input logic [AW-1:0] p);
        return (p == '0) ? AW'(TAPS - 1) : p - AW'(1);
    endfunction

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(TAPS - 1)) ? '0 : p + AW'(1);
    endfunction

`ifdef FIR_TAP_SEQ_COEFF_WR_EN
    logic coeff_wr;

    // Writes only land while idle; out-of-range indices (non power-of-2 TAPS) are dropped.
    assign coeff_wr = coeff_wr_en_in && (state == IDLE) && (int'(coeff_wr_addr_in) < TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) coeff[i] <= '0;
        end else if (coeff_wr) begin
            coeff[coeff_wr_addr_in] <= coeff_wr_data_in;
        end
    end

    // Tap 0 is registered on the accept edge, so a same-cycle write to index 0 is forwarded.
    assign coeff0 = (coeff_wr && coeff_wr_addr_in == '0) ? coeff_wr_data_in : coeff[0];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS; i++) coeff[i] <= COEFF_WIDTH'(fir_default_coeff(i));
        end
    end

    assign coeff0 = coeff[0];
`endif

    fir_filter_delay_line #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (TAPS)
    ) u_delay_line (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (sample_in),
        .rd_addr (rd_ptr),
        .rd_data (dl_rd)
    );

    // Output registers are loaded with the *next* tap each cycle; rd_ptr runs one
    // slot ahead of the tap being presented, and tap 0 bypasses the delay line.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            k                <= '0;
            rd_ptr           <= '0;
            sample_ready_out <= 1'b0;
            mult_sample_out  <= '0;
            mult_coeff_out   <= '0;
            tap_valid_out    <= 1'b0;
            overwrite_out    <= 1'b0;
            last_out         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state            <= RUN;
                        k                <= '0;
                        rd_ptr           <= ptr_dec(wr_ptr);
                        sample_ready_out <= 1'b0;
                        mult_sample_out  <= sample_in;
                        mult_coeff_out   <= coeff0;
                        tap_valid_out    <= 1'b1;
                        overwrite_out    <= 1'b1;
                        last_out         <= 1'b0;
                    end else begin
                        sample_ready_out <= 1'b1;
                    end
                end
                RUN: begin
                    if (k == AW'(TAPS - 1)) begin
                        state            <= IDLE;
                        k                <= '0;
                        wr_ptr           <= ptr_inc(wr_ptr);
                        sample_ready_out <= 1'b1;
                        mult_sample_out  <= '0;
                        mult_coeff_out   <= '0;
                        tap_valid_out    <= 1'b0;
                        overwrite_out    <= 1'b0;
                        last_out         <= 1'b0;
                    end else begin
                        k               <= k + AW'(1);
                        rd_ptr          <= ptr_dec(rd_ptr);
                        mult_sample_out <= dl_rd;
                        mult_coeff_out  <= coeff[k + AW'(1)];
                        overwrite_out   <= 1'b0;
                        last_out        <= (k == AW'(TAPS - 2));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_tap_sequencer.sv
// Scoreboard bench for fir_filter_tap_sequencer (TAPS=4); coefficient-write hazards
// are exercised when FIR_TAP_SEQ_COEFF_WR_EN is defined.
module tb_fir_filter_tap_sequencer;

    localparam int TAPS = 4;
    localparam int DW   = 16;
    localparam int CW   = 16;
    localparam int AW   = 2;

    typedef struct packed {
        logic [DW-1:0] s;
        logic [CW-1:0] c;
        logic          ov;
        logic          last;
    } tap_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] sample_in = '0;
    logic          sample_valid_in = 1'b0;
    logic          sample_ready_out;
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
    logic          coeff_wr_en_in = 1'b0;
    logic [AW-1:0] coeff_wr_addr_in = '0;
    logic [CW-1:0] coeff_wr_data_in = '0;
`endif
    logic [DW-1:0] mult_sample_out;
    logic [CW-1:0] mult_coeff_out;
    logic          tap_valid_out;
    logic          overwrite_out;
    logic          last_out;

    fir_filter_tap_sequencer #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .TAPS        (TAPS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_in        (sample_in),
        .sample_valid_in  (sample_valid_in),
        .sample_ready_out (sample_ready_out),
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
        .coeff_wr_en_in   (coeff_wr_en_in),
        .coeff_wr_addr_in (coeff_wr_addr_in),
        .coeff_wr_data_in (coeff_wr_data_in),
`endif
        .mult_sample_out  (mult_sample_out),
        .mult_coeff_out   (mult_coeff_out),
        .tap_valid_out    (tap_valid_out),
        .overwrite_out    (overwrite_out),
        .last_out         (last_out)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sample history as a newest-first list, ready as "TAPS+1 cycles per sample".
    tap_t exp_q[$];
    int   hist[$] = '{0, 0, 0, 0};
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
    int   cm[TAPS] = '{0, 0, 0, 0};
`else
    int   cm[TAPS] = '{1, 2, 3, 4};
`endif
    logic ready_m   = 1'b0;
    int   busy      = 0;
    int   cyc       = 0;
    logic acc_pulse = 1'b0;
    int   acc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        acc_pulse <= 1'b0;
        if (rst) begin
            exp_q.delete();
            hist = '{0, 0, 0, 0};
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
            cm = '{0, 0, 0, 0};
`endif
            ready_m <= 1'b0;
            busy    <= 0;
        end else if (ready_m) begin
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
            if (coeff_wr_en_in) cm[coeff_wr_addr_in] = int'(coeff_wr_data_in);
`endif
            if (sample_valid_in) begin
                hist.push_front(int'(sample_in));
                void'(hist.pop_back());
                for (int t = 0; t < TAPS; t++)
                    exp_q.push_back('{s: DW'(hist[t]), c: CW'(cm[t]), ov: (t == 0), last: (t == TAPS - 1)});
                ready_m   <= 1'b0;
                busy      <= TAPS;
                acc_pulse <= 1'b1;
                acc_cyc.push_back(cyc);
            end
        end else if (busy > 1) begin
            busy <= busy - 1;
        end else begin
            busy    <= 0;
            ready_m <= 1'b1;
        end
    end

    // Monitor: every cycle, ready must match the model; any presented tap must match the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            tap_t e;
            check("ready", 64'(sample_ready_out), 64'(ready_m));
            if (tap_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_tap", 64'(tap_valid_out), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("tap", 64'({mult_sample_out, mult_coeff_out, overwrite_out, last_out}), 64'(e));
                end
            end else begin
                check("idle_zero", 64'({mult_sample_out, mult_coeff_out, overwrite_out, last_out}), 64'(0));
            end
        end
    end

    task automatic wait_acc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (acc_pulse) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic send(input logic [DW-1:0] s);
        bit ok;
        sample_in       = s;
        sample_valid_in = 1'b1;
        wait_acc(ok);
        if (!ok) check("accept_timeout", 64'(0), 64'(1));
        sample_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle(n);
        rst = 1'b0;
    endtask

`ifdef FIR_TAP_SEQ_COEFF_WR_EN
    task automatic coeff_write(input int a, input int d);
        coeff_wr_en_in   = 1'b1;
        coeff_wr_addr_in = AW'(a);
        coeff_wr_data_in = CW'(d);
        idle(1);
        coeff_wr_en_in   = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        check("reset_ready", 64'(sample_ready_out), 64'(0));
        check("reset_tap_valid", 64'(tap_valid_out), 64'(0));
        rst = 1'b0;
        idle(1);
        check("ready_after_reset", 64'(sample_ready_out), 64'(1));

`ifdef FIR_TAP_SEQ_COEFF_WR_EN
        for (int i = 0; i < TAPS; i++) coeff_write(i, i + 1);
`endif

        // Impulse then history order.
        send(16'd5);
        idle(6);
        send(16'd7);
        idle(6);

        // Wrap of the circular history.
        do_reset(2);
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
        for (int i = 0; i < TAPS; i++) coeff_write(i, i + 1);
`endif
        for (int v = 1; v <= 6; v++) send(DW'(v));
        idle(6);

`ifdef FIR_TAP_SEQ_COEFF_WR_EN
        // Write during RUN is dropped; write coincident with accept lands in that run.
        send(16'd11);
        coeff_write(2, 9);
        idle(6);
        coeff_wr_en_in   = 1'b1;
        coeff_wr_addr_in = 2'd2;
        coeff_wr_data_in = 16'd9;
        send(16'd13);
        coeff_wr_en_in   = 1'b0;
        idle(6);
`endif

        // Reset while tap 1 is on the outputs.
        send(16'd21);
        idle(1);
        rst = 1'b1;
        idle(1);
        check("midrun_rst_valid", 64'(tap_valid_out), 64'(0));
        check("midrun_rst_last", 64'(last_out), 64'(0));
        rst = 1'b0;
        idle(1);
        check("ready_after_release", 64'(sample_ready_out), 64'(1));
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
        for (int i = 0; i < TAPS; i++) coeff_write(i, i + 1);
`endif
        send(16'd22);
        idle(6);

        // Continuous valid: one accept every TAPS+1 cycles, each sample exactly once.
        acc_cyc.delete();
        sample_valid_in = 1'b1;
        for (int n = 0; n < 10; n++) begin
            sample_in = DW'($urandom);
            wait_acc(ok);
            if (!ok) check("stream_timeout", 64'(0), 64'(1));
        end
        sample_valid_in = 1'b0;
        check("stream_count", 64'(acc_cyc.size()), 64'(10));
        for (int i = 1; i < acc_cyc.size(); i++)
            check("stream_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'(TAPS + 1));
        idle(6);

        // Random traffic with random gaps.
        for (int n = 0; n < 30; n++) begin
            idle($urandom_range(0, 7));
`ifdef FIR_TAP_SEQ_COEFF_WR_EN
            if ($urandom_range(0, 3) == 0) coeff_write($urandom_range(0, TAPS - 1), $urandom);
`endif
            send(DW'($urandom));
        end

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
        check("drain", 64'(exp_q.size()), 64'(0));
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
